// File: rtl/nn_calc_sequencer.sv
// Dot-product sequencer: walks pixel/weight memories, accumulates saturated
// signed products per output neuron and writes each finished sum out.
module nn_calc_sequencer #(
  parameter int N_IN  = 784,
  parameter int N_OUT = 10,
  parameter int P_AW  = 11,
  parameter int W_AW  = 14
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            start_calc,
  input  logic            abort,
  output logic            rd_en,
  output logic [P_AW-1:0] pixel_addr,
  output logic [W_AW-1:0] weight_addr,
  input  logic [15:0]     pixel_data,
  input  logic [15:0]     weight_data,
  output logic            result_wr_en,
  output logic [3:0]      result_addr,
  output logic [31:0]     result_data,
  output logic            busy,
  output logic            done_calc
);

  // state   | meaning
  // IDLE    | waiting for start_calc
  // RUN     | one pixel/weight read issued per cycle
  // DRAIN   | last read's data accumulated, no new read
  // WRITE   | finished neuron sum presented on result port
  // DONE    | one-cycle completion pulse
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WRITE, S_DONE} state_t;

  localparam logic [P_AW-1:0] IN_LAST  = P_AW'(N_IN - 1);
  localparam logic [3:0]      OUT_LAST = 4'(N_OUT - 1);

  state_t             state;
  logic [P_AW-1:0]    in_idx;
  logic [W_AW-1:0]    w_ptr;
  logic [3:0]         out_idx;
  logic signed [31:0] acc;
  logic [31:0]        res_q;
  logic               data_vld;
  logic               first_data;

  logic signed [31:0] px_ext;
  logic signed [31:0] wt_ext;
  logic signed [31:0] prod;
  logic [32:0]        sum;
  logic signed [31:0] acc_nxt;

  always_comb begin
    px_ext  = {{16{pixel_data[15]}}, pixel_data};
    wt_ext  = {{16{weight_data[15]}}, weight_data};
    prod    = px_ext * wt_ext;
    sum     = {acc[31], acc} + {prod[31], prod};
    acc_nxt = sum[31:0];
    if (first_data)
      acc_nxt = prod;
    else if (sum[32] != sum[31])
      acc_nxt = sum[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= S_IDLE;
      in_idx     <= '0;
      w_ptr      <= '0;
      out_idx    <= '0;
      acc        <= '0;
      res_q      <= '0;
      data_vld   <= 1'b0;
      first_data <= 1'b0;
    end else begin
      data_vld <= 1'b0;
      if (data_vld)
        acc <= acc_nxt;
      // abort beats everything, including a simultaneous start in IDLE
      if (abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_calc) begin
              state   <= S_RUN;
              in_idx  <= '0;
              w_ptr   <= '0;
              out_idx <= '0;
            end
          end
          S_RUN: begin
            data_vld   <= 1'b1;
            first_data <= (in_idx == '0);
            w_ptr      <= w_ptr + 1'b1;
            if (in_idx == IN_LAST) begin
              in_idx <= '0;
              state  <= S_DRAIN;
            end else begin
              in_idx <= in_idx + 1'b1;
            end
          end
          S_DRAIN: begin
            res_q <= acc_nxt;
            state <= S_WRITE;
          end
          S_WRITE: begin
            if (out_idx == OUT_LAST) begin
              state <= S_DONE;
            end else begin
              out_idx <= out_idx + 1'b1;
              state   <= S_RUN;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign rd_en        = (state == S_RUN);
  assign result_wr_en = (state == S_WRITE);
  assign busy         = (state != S_IDLE);
  assign done_calc    = (state == S_DONE);
  assign pixel_addr   = in_idx;
  assign weight_addr  = w_ptr;
  assign result_addr  = out_idx;
  assign result_data  = res_q;

endmodule

// File: tb/tb_nn_calc_sequencer.sv
// Bench for nn_calc_sequencer: small memories, observed read/write/done
// traces compared against an arithmetic model of the job.
module tb_nn_calc_sequencer;
  localparam int TN_IN  = 4;
  localparam int TN_OUT = 2;
  localparam int TP     = 4;
  localparam int TW     = 4;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start_calc;
  logic          abort;
  logic          rd_en;
  logic [TP-1:0] pixel_addr;
  logic [TW-1:0] weight_addr;
  logic [15:0]   pixel_data;
  logic [15:0]   weight_data;
  logic          result_wr_en;
  logic [3:0]    result_addr;
  logic [31:0]   result_data;
  logic          busy;
  logic          done_calc;

  logic signed [15:0] pmem [0:15];
  logic signed [15:0] wmem [0:15];

  int errors = 0;
  int checks = 0;
  int rd_p[$], rd_w[$], wr_a[$], wr_k[$];
  logic [31:0] wr_d[$];
  int done_k;

  nn_calc_sequencer #(.N_IN(TN_IN), .N_OUT(TN_OUT), .P_AW(TP), .W_AW(TW)) dut (
    .clk(clk), .n_rst(n_rst), .start_calc(start_calc), .abort(abort),
    .rd_en(rd_en), .pixel_addr(pixel_addr), .weight_addr(weight_addr),
    .pixel_data(pixel_data), .weight_data(weight_data),
    .result_wr_en(result_wr_en), .result_addr(result_addr),
    .result_data(result_data), .busy(busy), .done_calc(done_calc)
  );

  always #5 clk = ~clk;

  // one-cycle-latency memories
  always @(posedge clk) begin
    if (rd_en) begin
      pixel_data  <= pmem[pixel_addr];
      weight_data <= wmem[weight_addr];
    end
  end

  function automatic logic [31:0] ref_neuron(input int n);
    longint acc = 0;
    for (int i = 0; i < TN_IN; i++) begin
      acc = acc + longint'(pmem[i]) * longint'(wmem[n*TN_IN+i]);
      if (acc > 64'sd2147483647) acc = 64'sd2147483647;
      else if (acc < -64'sd2147483648) acc = -64'sd2147483648;
    end
    return 32'(acc);
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      pmem[i] = 16'($urandom);
      wmem[i] = 16'($urandom);
    end
  endtask

  // Starts a job at the current negedge; k counts edges after the one sampling start.
  task automatic do_job(input string tag, input int abort_k, input int restart_k);
    int ep[$], ew[$], ea[$], ek[$];
    logic [31:0] ed[$];
    int exp_done, kk;
    rd_p.delete(); rd_w.delete(); wr_a.delete(); wr_d.delete(); wr_k.delete();
    done_k = -1;
    start_calc = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_calc = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (rd_en) begin rd_p.push_back(int'(pixel_addr)); rd_w.push_back(int'(weight_addr)); end
      if (result_wr_en) begin
        wr_a.push_back(int'(result_addr)); wr_d.push_back(result_data); wr_k.push_back(k);
      end
      if (done_calc && done_k < 0) done_k = k;
      if (abort_k >= 0 && k == abort_k + 1) begin
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0 || result_wr_en !== 1'b0)
          begin errors++; $display("FAIL %s abort_idle: busy=%b rd_en=%b wr=%b want 000", tag, busy, rd_en, result_wr_en); end
        break;
      end
      if (done_k >= 0) break;
      abort      = (k == abort_k);
      start_calc = (k == restart_k);
      @(negedge clk);
    end
    abort = 1'b0;
    start_calc = 1'b0;

    for (int n = 0; n < TN_OUT; n++) begin
      for (int i = 0; i < TN_IN; i++) begin
        kk = n*(TN_IN+2) + i;
        if (abort_k < 0 || kk <= abort_k) begin ep.push_back(i); ew.push_back(n*TN_IN+i); end
      end
      kk = n*(TN_IN+2) + TN_IN + 1;
      if (abort_k < 0 || kk <= abort_k) begin ea.push_back(n); ed.push_back(ref_neuron(n)); ek.push_back(kk); end
    end
    exp_done = (abort_k < 0) ? TN_OUT*(TN_IN+2) : -1;

    checks++;
    if (rd_p.size() != ep.size())
      begin errors++; $display("FAIL %s read_count: got %0d want %0d", tag, rd_p.size(), ep.size()); end
    for (int j = 0; j < rd_p.size() && j < ep.size(); j++) begin
      checks++;
      if (rd_p[j] !== ep[j] || rd_w[j] !== ew[j])
        begin errors++; $display("FAIL %s read_addr[%0d]: got p=%0d w=%0d want p=%0d w=%0d", tag, j, rd_p[j], rd_w[j], ep[j], ew[j]); end
    end
    checks++;
    if (wr_a.size() != ea.size())
      begin errors++; $display("FAIL %s write_count: got %0d want %0d", tag, wr_a.size(), ea.size()); end
    for (int j = 0; j < wr_a.size() && j < ea.size(); j++) begin
      checks++;
      if (wr_a[j] !== ea[j] || wr_d[j] !== ed[j] || wr_k[j] !== ek[j])
        begin errors++; $display("FAIL %s write[%0d]: got addr=%0d data=%h k=%0d want addr=%0d data=%h k=%0d",
                                 tag, j, wr_a[j], wr_d[j], wr_k[j], ea[j], ed[j], ek[j]); end
    end
    checks++;
    if (done_k !== exp_done)
      begin errors++; $display("FAIL %s done_time: got %0d want %0d", tag, done_k, exp_done); end
    if (done_k >= 0) begin
      @(negedge clk);
      checks++;
      if (done_calc !== 1'b0 || busy !== 1'b0)
        begin errors++; $display("FAIL %s done_pulse: done=%b busy=%b want 00", tag, done_calc, busy); end
      checks++;
      if (result_data !== ed[ed.size()-1])
        begin errors++; $display("FAIL %s result_hold: got %h want %h", tag, result_data, ed[ed.size()-1]); end
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; start_calc = 1'b0; abort = 1'b0;
    fill_random();
    @(negedge clk); @(negedge clk);
    checks++;
    if ({rd_en, pixel_addr, weight_addr, result_wr_en, result_addr, result_data, busy, done_calc} !== '0)
      begin errors++; $display("FAIL reset_outputs: got rd=%b p=%0d w=%0d wr=%b a=%0d d=%h busy=%b done=%b want all 0",
                               rd_en, pixel_addr, weight_addr, result_wr_en, result_addr, result_data, busy, done_calc); end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) pmem[i] = 16'(i + 1);
    for (int i = 0; i < 4; i++) wmem[i] = 16'sd1;
    wmem[4] = 16'sd2; wmem[5] = 16'sd0; wmem[6] = 16'sd0; wmem[7] = -16'sd1;
    do_job("basic", -1, -1);
    checks++;
    if (wr_d.size() != 2 || wr_d[0] !== 32'h0000_000A || wr_d[1] !== 32'hFFFF_FFFE)
      begin errors++; $display("FAIL basic_values: got %0d writes want 0000000a,fffffffe", wr_d.size()); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 16; i++) begin pmem[i] = 16'sh7FFF; wmem[i] = 16'sh7FFF; end
    do_job("sat_pos", -1, -1);
    checks++;
    if (wr_d.size() < 1 || wr_d[0] !== 32'h7FFF_FFFF)
      begin errors++; $display("FAIL sat_pos_value: got %h want 7fffffff", result_data); end
    for (int i = 0; i < 16; i++) pmem[i] = 16'sh8000;
    do_job("sat_neg", -1, -1);
    checks++;
    if (wr_d.size() < 1 || wr_d[0] !== 32'h8000_0000)
      begin errors++; $display("FAIL sat_neg_value: got %h want 80000000", result_data); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      fill_random();
      if (r == 5) for (int i = 0; i < 16; i++) begin pmem[i] = 16'sh8000; wmem[i] = 16'sh8000; end
      do_job("random", -1, -1);
    end
  endtask

  task automatic test_ignored_start();
    fill_random();
    do_job("ignored_start", -1, 2);
  endtask

  task automatic test_abort();
    fill_random();
    do_job("abort", TN_IN + 2 + 1, -1);
    do_job("after_abort", -1, -1);
  endtask

  task automatic test_abort_start_idle();
    abort = 1'b1; start_calc = 1'b1;
    @(negedge clk);
    abort = 1'b0; start_calc = 1'b0;
    checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0)
      begin errors++; $display("FAIL abort_start_idle: busy=%b rd_en=%b want 00", busy, rd_en); end
  endtask

  task automatic test_back_to_back();
    fill_random();
    do_job("b2b_first", -1, -1);
    do_job("b2b_second", -1, -1);
  endtask

  task automatic test_reset_midrun();
    fill_random();
    start_calc = 1'b1;
    @(negedge clk);
    start_calc = 1'b0;
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    checks++;
    if ({rd_en, pixel_addr, weight_addr, result_wr_en, result_addr, result_data, busy, done_calc} !== '0)
      begin errors++; $display("FAIL reset_midrun: got rd=%b p=%0d w=%0d busy=%b d=%h want all 0", rd_en, pixel_addr, weight_addr, busy, result_data); end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    do_job("after_reset", -1, -1);
  endtask

  initial begin
    pixel_data = '0;
    weight_data = '0;
    test_reset();
    test_basic();
    test_saturation();
    test_random();
    test_ignored_start();
    test_abort();
    test_abort_start_idle();
    test_back_to_back();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nn_calc_sequencer.md
Name: nn_calc_sequencer

Overview:
Controller that sequences the neural-network dot-product datapath once the Avalon bus interface has loaded pixel and weight memories and pulsed start_calc. It walks the pixel and weight address spaces, issues one memory read per cycle, and accumulates signed 16x16 products per output neuron with saturation. Each finished neuron is written to the output result registers, and done_calc is pulsed back to the bus interface when all neurons are complete.

Parameters:
N_IN, 784, inputs (pixels) per neuron.
N_OUT, 10, output neurons; must be <= 16.
P_AW, 11, pixel memory address width.
W_AW, 14, weight memory address width; 2^W_AW >= N_IN*N_OUT.

Ports:
clk  input  1  clock, rising edge.
n_rst  input  1  reset, asynchronous, active-low.
start_calc  input  1  one-cycle start request from bus interface.
abort  input  1  synchronous cancel of a running job.
rd_en  output  1  read strobe to pixel and weight memories.
pixel_addr  output  P_AW  pixel read address.
weight_addr  output  W_AW  weight read address.
pixel_data  input  16  signed pixel; valid the cycle after rd_en.
weight_data  input  16  signed weight; valid the cycle after rd_en.
result_wr_en  output  1  result register write strobe.
result_addr  output  4  output neuron index.
result_data  output  32  signed saturated neuron sum.
busy  output  1  high from first RUN cycle through DONE.
done_calc  output  1  one-cycle completion pulse.

Behaviour:
- Reset, asynchronous on n_rst=0. All outputs are 0. State is IDLE. in_idx, out_idx, weight pointer and accumulator are cleared.
- All outputs are registered or decoded from the registered state. There is no combinational path from any input to any output.
- Memory read latency is fixed at 1 cycle: data for an rd_en issued in cycle k is consumed in cycle k+1.
- FSM states: IDLE, RUN, DRAIN, WRITE, DONE.
- IDLE:
  - start_calc=1 moves to RUN; in_idx=0 and out_idx=0.
  - The weight pointer restarts at 0 on every start.
- RUN:
  - rd_en=1, pixel_addr=in_idx, weight_addr=weight pointer.
  - in_idx and the weight pointer each increment by 1 every cycle.
  - When in_idx==N_IN-1 is issued, go to DRAIN and reset in_idx to 0.
  - The weight pointer is not reset, so weight_addr = out_idx*N_IN + in_idx. It is produced with a counter, not a multiplier.
- Accumulate (RUN cycles 2..N_IN and DRAIN): acc <= sat32(acc + pixel_data*weight_data).
  - Exception: the first data cycle of each neuron loads acc <= product, which implicitly clears acc.
  - The product is a full 32-bit signed value.
  - sat32 clamps to 0x7FFFFFFF or 0x80000000 on signed overflow.
- DRAIN: rd_en=0, final accumulate, go to WRITE.
- WRITE:
  - result_wr_en=1, result_addr=out_idx, result_data=acc.
  - If out_idx==N_OUT-1, go to DONE; otherwise out_idx++ and go to RUN.
- DONE: done_calc=1 for exactly one cycle, then IDLE. busy drops when leaving DONE.
- Per-neuron time is N_IN+2 cycles. done_calc is high in the cycle after the N_OUT*(N_IN+2)-th rising edge following the edge that sampled start_calc.
- start_calc while not in IDLE is ignored. It is not queued and causes no restart.
- abort=1 in any non-IDLE state moves to IDLE on the next edge:
  - rd_en, result_wr_en and busy go low on that edge.
  - done_calc is never asserted for the aborted job.
  - Results already written stay written.
- abort together with start_calc in IDLE: abort wins and the FSM stays IDLE.
- n_rst asserted mid-job: immediate return to the reset state, no partial write.
- result_data holds its last value when result_wr_en=0. It is not cleared between jobs, only on reset.

Test Plan:
- Reset: assert n_rst=0 mid-RUN -> all outputs 0 immediately and FSM in IDLE. A fresh start_calc then completes normally.
- Basic, N_IN=4, N_OUT=2, pixels 1,2,3,4:
  - Weights n0 = 1,1,1,1 -> result_addr 0, result_data 0x0000000A.
  - Weights n1 = 2,0,0,-1 -> result_addr 1, result_data 0xFFFFFFFE.
  - done_calc pulses once, 12 edges after start is sampled.
  - weight_addr sequence is 0..7 and pixel_addr repeats 0..3.
- Saturation, N_IN=4:
  - All pixels and weights 0x7FFF -> result_data 0x7FFFFFFF.
  - Pixels 0x8000 with weights 0x7FFF -> 0x80000000.
- Ignored start: pulse start_calc again mid-RUN -> address sequence, results and done timing are identical to a single start.
- Abort: abort in the 2nd RUN cycle of neuron 1 -> neuron 0 is written, neuron 1 is never written, no done_calc, busy=0 next cycle. A later start runs a full job.
- Back-to-back: start_calc the cycle after done_calc -> second job produces identical results, with weight_addr restarting at 0.
